// File: rtl/decode_stage_pipelined.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : decode_stage_pipelined
// Brief    : RV64I-subset decode stage: register file with write-back bypass,
//            control/immediate decode, load-use stall and a registered ID/EX.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_pipelined #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic            out_branch,
    output logic            out_memread,
    output logic            out_memtoreg,
    output logic            out_memwrite,
    output logic            out_alusrc,
    output logic            out_regwrite,
    output logic [1:0]      out_aluop,
    output logic            out_illegal
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [5:0] c_NREGS     = 6'(NUM_REGS);

    logic [XLEN-1:0] r_regs [NUM_REGS];

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_imm;
    logic            w_rs1_used, w_rs2_used;
    logic            w_branch, w_memread, w_memtoreg, w_memwrite;
    logic            w_alusrc, w_regwrite, w_illegal;
    logic [1:0]      w_aluop;
    logic            w_wb_ok, w_hazard, w_accept;
    logic            w_unused_funct3;

    logic            r_valid;
    logic [XLEN-1:0] r_a, r_b, r_imm;
    logic [4:0]      r_rd;
    logic            r_branch, r_memread, r_memtoreg, r_memwrite;
    logic            r_alusrc, r_regwrite, r_illegal;
    logic [1:0]      r_aluop;

    assign w_opcode        = in_instr[6:0];
    assign w_rd            = in_instr[11:7];
    assign w_rs1           = in_instr[19:15];
    assign w_rs2           = in_instr[24:20];
    assign w_unused_funct3 = ^in_instr[14:12];

    // Indices at or above NUM_REGS do not exist: never written, read as zero.
    assign w_wb_ok = wb_en && (wb_rd != 5'd0) && ({1'b0, wb_rd} < c_NREGS);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wb_ok) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        w_rs1_val = '0;
        if (w_rs1 != 5'd0 && {1'b0, w_rs1} < c_NREGS)
            w_rs1_val = (wb_en && wb_rd == w_rs1) ? wb_data : r_regs[w_rs1];
    end

    always_comb begin
        w_rs2_val = '0;
        if (w_rs2 != 5'd0 && {1'b0, w_rs2} < c_NREGS)
            w_rs2_val = (wb_en && wb_rd == w_rs2) ? wb_data : r_regs[w_rs2];
    end

    always_comb begin
        w_branch   = 1'b0;
        w_memread  = 1'b0;
        w_memtoreg = 1'b0;
        w_memwrite = 1'b0;
        w_alusrc   = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        w_aluop    = 2'b00;
        w_imm      = '0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_aluop    = 2'b10;
                w_regwrite = 1'b1;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            c_OP_IMM: begin
                w_aluop    = 2'b11;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_rs1_used = 1'b1;
                w_imm      = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            end
            c_OP_LOAD: begin
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_rs1_used = 1'b1;
                w_imm      = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            end
            c_OP_STORE: begin
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_imm      = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            c_OP_BRANCH: begin
                w_aluop    = 2'b01;
                w_branch   = 1'b1;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_imm      = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // A load in ID/EX cannot forward its data yet; consumers must wait a cycle.
    assign w_hazard = in_valid && r_valid && r_memread && (r_rd != 5'd0) &&
                      ((w_rs1_used && (w_rs1 == r_rd)) || (w_rs2_used && (w_rs2 == r_rd)));
    assign in_ready = (!r_valid || out_ready) && !w_hazard && !Reset;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge Clk) begin
        if (Reset || (!w_accept && out_ready)) begin
            r_valid    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_branch   <= 1'b0;
            r_memread  <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_illegal  <= 1'b0;
            r_aluop    <= 2'b00;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_a        <= w_rs1_val;
            r_b        <= w_rs2_val;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_branch   <= w_branch;
            r_memread  <= w_memread;
            r_memtoreg <= w_memtoreg;
            r_memwrite <= w_memwrite;
            r_alusrc   <= w_alusrc;
            r_regwrite <= w_regwrite;
            r_illegal  <= w_illegal;
            r_aluop    <= w_aluop;
        end
    end

    assign out_valid    = r_valid;
    assign out_a        = r_a;
    assign out_b        = r_b;
    assign out_imm      = r_imm;
    assign out_rd       = r_rd;
    assign out_branch   = r_branch;
    assign out_memread  = r_memread;
    assign out_memtoreg = r_memtoreg;
    assign out_memwrite = r_memwrite;
    assign out_alusrc   = r_alusrc;
    assign out_regwrite = r_regwrite;
    assign out_illegal  = r_illegal;
    assign out_aluop    = r_aluop;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipelined.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_pipelined
// Brief    : Directed scoreboard bench for decode_stage_pipelined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage_pipelined;

    localparam logic [6:0] c_BR  = 7'b1000000;
    localparam logic [6:0] c_MR  = 7'b0100000;
    localparam logic [6:0] c_MTR = 7'b0010000;
    localparam logic [6:0] c_MW  = 7'b0001000;
    localparam logic [6:0] c_AS  = 7'b0000100;
    localparam logic [6:0] c_RW  = 7'b0000010;
    localparam logic [6:0] c_ILL = 7'b0000001;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [1:0]  aluop;
        logic [6:0]  ctl;
    } exp_t;

    logic        Clk = 1'b0, Reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_instr = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [63:0] out_a, out_b, out_imm;
    logic [4:0]  out_rd;
    logic        out_branch, out_memread, out_memtoreg, out_memwrite;
    logic        out_alusrc, out_regwrite, out_illegal;
    logic [1:0]  out_aluop;
    logic [6:0]  ctl;
    exp_t        act;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    decode_stage_pipelined #(.XLEN(64), .NUM_REGS(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_rd(out_rd),
        .out_branch(out_branch), .out_memread(out_memread), .out_memtoreg(out_memtoreg),
        .out_memwrite(out_memwrite), .out_alusrc(out_alusrc), .out_regwrite(out_regwrite),
        .out_aluop(out_aluop), .out_illegal(out_illegal)
    );

    always #5 Clk = ~Clk;

    assign ctl = {out_branch, out_memread, out_memtoreg, out_memwrite,
                  out_alusrc, out_regwrite, out_illegal};
    assign act = {out_a, out_b, out_imm, out_rd, out_aluop, ctl};

    function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] imm, input logic [4:0] rd,
                                input logic [1:0] aluop, input logic [6:0] c);
        exp_t e;
        e.a = a; e.b = b; e.imm = imm; e.rd = rd; e.aluop = aluop; e.ctl = c;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Present an instruction, wait (bounded) for acceptance, record its expected entry.
    task automatic issue(input logic [31:0] ins, input exp_t e);
        int n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge Clk);
        while (!in_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("accept", {63'b0, in_ready}, 64'd1);
        if (in_ready) q.push_back(e);
        step();
        in_valid = 1'b0;
        if (n < 20) chk("latency_out_valid", {63'b0, out_valid}, 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (2) step();
    endtask

    // Monitor: every cycle the entry is valid it must match the oldest expectation.
    initial begin
        forever begin
            @(negedge Clk);
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_entry: out_valid=1 rd=%0d with no entry expected", out_rd);
                end else begin
                    if (act !== q[0]) begin
                        errors++;
                        $display("FAIL entry: got a=%h b=%h imm=%h rd=%0d aluop=%b ctl=%b expected a=%h b=%h imm=%h rd=%0d aluop=%b ctl=%b",
                                 out_a, out_b, out_imm, out_rd, out_aluop, ctl,
                                 q[0].a, q[0].b, q[0].imm, q[0].rd, q[0].aluop, q[0].ctl);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        // Reset: no acceptance, cleared ID/EX
        in_valid = 1'b1;
        in_instr = 32'h000281B3;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd0);
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_fields", {39'b0, out_rd, out_aluop, ctl, 11'b0} | out_a | out_imm, 64'd0);
        step();
        in_valid = 1'b0;
        Reset    = 1'b0;
        step();

        // Write x5, then add x3,x5,x0
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234;
        step();
        wb_en = 1'b0;
        issue(32'h000281B3, mk(64'h1234, 64'd0, 64'd0, 5'd3, 2'b10, c_RW));
        drain();

        // addi x1,x5,10 with same-cycle write-back to x5 (bypass)
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'hAA;
        issue(32'h00A28093, mk(64'hAA, 64'd0, 64'd10, 5'd1, 2'b11, c_AS | c_RW));
        wb_en = 1'b0;
        drain();

        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'h55;
        step();
        wb_rd = 5'd2; wb_data = 64'h100;
        step();
        wb_en = 1'b0;

        // ld x7,-8(x2) followed by dependent add x8,x7,x1
        issue(32'hFF813383, mk(64'h100, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 5'd7, 2'b00,
                               c_MR | c_MTR | c_AS | c_RW));
        in_valid = 1'b1;
        in_instr = 32'h00138433;
        @(negedge Clk);
        chk("load_use_stall", {63'b0, in_ready}, 64'd0);
        step();
        @(negedge Clk);
        chk("bubble_valid", {63'b0, out_valid}, 64'd0);
        chk("bubble_fields", {50'b0, out_rd, out_aluop, ctl} | out_a | out_imm, 64'd0);
        chk("hazard_clear", {63'b0, in_ready}, 64'd1);
        if (in_ready) q.push_back(mk(64'd0, 64'h55, 64'd0, 5'd8, 2'b10, c_RW));
        step();
        in_valid = 1'b0;
        chk("add_after_bubble", {63'b0, out_valid}, 64'd1);
        drain();

        // Backpressure: sd x5,16(x1) held 3 cycles while x1 is rewritten
        out_ready = 1'b0;
        issue(32'h0050B823, mk(64'h55, 64'hAA, 64'd16, 5'd16, 2'b00, c_MW | c_AS));
        in_valid = 1'b1;
        in_instr = 32'hFFF08493;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
            step();
            wb_en = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge Clk);
        chk("release_in_ready", {63'b0, in_ready}, 64'd1);
        if (in_ready) q.push_back(mk(64'h77, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 2'b11, c_AS | c_RW));
        step();
        in_valid = 1'b0;
        chk("release_out_valid", {63'b0, out_valid}, 64'd1);
        drain();

        // Illegal opcode, then beq x1,x2,+16
        issue(32'h0000007F, mk(64'd0, 64'd0, 64'd0, 5'd0, 2'b00, c_ILL));
        issue(32'h00208863, mk(64'h77, 64'h100, 64'd16, 5'd16, 2'b01, c_BR));
        drain();

        // x0 write ignored, also with same-cycle bypass attempt
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
        step();
        issue(32'h000001B3, mk(64'd0, 64'd0, 64'd0, 5'd3, 2'b10, c_RW));
        wb_en = 1'b0;
        drain();

        // Reset during a held entry, with a write-back that must be ignored
        out_ready = 1'b0;
        issue(32'h006281B3, mk(64'hAA, 64'd0, 64'd0, 5'd3, 2'b10, c_RW));
        in_valid = 1'b1;
        Reset = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd6; wb_data = 64'h99;
        @(negedge Clk);
        chk("reset_mid_in_ready", {63'b0, in_ready}, 64'd0);
        step();
        q.delete();
        Reset = 1'b0;
        wb_en = 1'b0;
        in_valid = 1'b0;
        @(negedge Clk);
        chk("reset_flush_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_flush_fields", {50'b0, out_rd, out_aluop, ctl} | out_a | out_b, 64'd0);
        out_ready = 1'b1;
        step();
        issue(32'h006281B3, mk(64'd0, 64'd0, 64'd0, 5'd3, 2'b10, c_RW));
        drain();

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Parametrised RV64I-subset instruction decode stage for the pipelined core.
- Sits between fetch (IF/ID handshake) and execute (ID/EX handshake).
- Contains the register file, control unit and immediate generator, plus a registered ID/EX output stage.
- Adds write-back bypass, load-use hazard stall with bubble insertion, illegal-opcode flagging, and valid/ready flow control.

Parameters:
- XLEN, 64, datapath width for registers, operands and immediates.
- NUM_REGS, 32, number of architectural registers. Legal values are 2..32. Register index width is fixed at 5 bits; indices >= NUM_REGS read as 0 and writes to them are ignored.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- wb_en  in  1  register write-back enable.
- wb_rd  in  5  write-back destination.
- wb_data  in  XLEN  write-back value.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute consumes the ID/EX entry.
- out_a, out_b  out  XLEN  rs1/rs2 operand values.
- out_imm  out  XLEN  sign-extended immediate.
- out_rd  out  5  destination register index.
- out_branch, out_memread, out_memtoreg, out_memwrite, out_alusrc, out_regwrite  out  1 each  control signals.
- out_aluop  out  2  ALU operation class.
- out_illegal  out  1  unsupported opcode.

Behaviour:
- Reset: out_valid=0; every ID/EX field=0; all registers=0. While Reset is high: in_ready=0 and register-file writes are ignored. Reset asserted mid-stall discards the held entry.
- Decode by opcode (instr[6:0]):
  - R-type 0110011: aluop=10, regwrite=1.
  - I-ALU 0010011: aluop=11, alusrc=1, regwrite=1.
  - Load 0000011: aluop=00, memread=1, memtoreg=1, alusrc=1, regwrite=1.
  - Store 0100011: aluop=00, memwrite=1, alusrc=1.
  - Branch 1100011: aluop=01, branch=1.
  - Any other opcode: all controls 0, illegal=1, imm=0. The instruction still flows down the pipeline with out_illegal=1.
- Immediates, sign-extended from instr[31] to XLEN:
  - I-type / load: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - R-type: 0.
- Operand usage: rs1 (instr[19:15]) is used by R, I-ALU, load, store and branch. rs2 (instr[24:20]) is used by R, store and branch.
- Register file:
  - Written on posedge when wb_en=1, wb_rd!=0 and wb_rd<NUM_REGS. Register x0 always reads 0.
  - Reads are combinational with write-through bypass: if wb_en=1, wb_rd!=0 and wb_rd equals the rs index, the read returns wb_data in the same cycle.
- Hazard:
  - hazard = out_valid & out_memread & (out_rd!=0) & ((rs1 used & rs1==out_rd) | (rs2 used & rs2==out_rd)).
  - Hazard is evaluated only when in_valid=1.
- Flow control:
  - in_ready = (!out_valid | out_ready) & !hazard & !Reset.
  - Accept (in_valid & in_ready): ID/EX loads the decoded fields and operands; out_valid=1 next cycle. Latency is 1 cycle from accept to out_valid.
  - Hazard with out_ready=1: ID/EX loads a bubble (out_valid=0, all fields 0). Next cycle the hazard clears and the instruction is accepted. Load-use penalty is exactly 1 cycle.
  - Hazard with out_ready=0: ID/EX holds its entry; in_ready=0.
  - No accept and out_ready=1: out_valid goes to 0.
  - out_valid=1 and out_ready=0: every output holds stable.
- Held-entry operands are not refreshed by later write-backs. Operands are captured at accept only.
- Simultaneous write-back and accept reading the same register: the new value is captured (bypass).

Test Plan:
- Reset, then wb_en=1, wb_rd=5, wb_data=0x1234 -> one cycle later, issue add x3,x5,x0 (0x000281B3) -> out_a=0x1234, out_b=0, out_aluop=10, out_regwrite=1, out_rd=3, out_valid=1 one cycle after accept.
- Issue addi x1,x5,10 in the same cycle as wb_rd=5, wb_data=0xAA -> out_a=0xAA (bypass), out_imm=10, out_alusrc=1, out_aluop=11.
- Issue ld x7,-8(x2) (0xFF813383) followed by add x8,x7,x1, with out_ready=1 -> ld: out_imm=0xFFFFFFFFFFFFFFF8, out_memread=1. Next cycle in_ready=0 and out_valid=0 (bubble). The add is accepted one cycle later.
- Hold out_ready=0 for 3 cycles with a valid entry -> in_ready=0 and all outputs stable. Release -> next instruction flows with no loss or duplication.
- Issue opcode 0x7F, then beq x1,x2,+16 (0x00208863) -> first: out_illegal=1, all controls 0. beq: out_branch=1, out_aluop=01, out_imm=16.
- Write wb_rd=0, wb_data=0xFF, then read x0 -> out_a=0. Assert Reset while out_valid=1 -> out_valid=0 and all registers read 0 afterward.
